// File: rtl/bus_req_issuer.sv
// rtl/bus_req_issuer.sv - MESI miss/upgrade bus request issuer with victim writeback, HITM retry and snoop timeout
package bus_req_issuer_pkg;

    typedef enum logic [1:0] {
        BUS_READ       = 2'd0,
        BUS_WRITE      = 2'd1,
        BUS_INVALIDATE = 2'd2,
        BUS_RWIM       = 2'd3
    } bus_operation_e;

    typedef enum logic [1:0] {
        SNOOP_NOHIT = 2'd0,
        SNOOP_HIT   = 2'd1,
        SNOOP_HITM  = 2'd2
    } snoop_result_e;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    localparam logic [1:0] KIND_RD_MISS  = 2'd0;
    localparam logic [1:0] KIND_WR_MISS  = 2'd1;
    localparam logic [1:0] KIND_WR_HIT_S = 2'd2;
    localparam logic [1:0] KIND_RESERVED = 2'd3;

endpackage

module bus_req_issuer
    import bus_req_issuer_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_kind,
    input  logic [31:0]    req_addr,
    input  logic           victim_dirty,
    input  logic [31:0]    victim_addr,
    output logic           bus_valid,
    input  logic           bus_ready,
    output bus_operation_e bus_op,
    output logic [31:0]    bus_addr,
    input  logic           snoop_valid,
    input  snoop_result_e  snoop_res,
    output logic           done_valid,
    output mesi_e          done_state,
    output logic           err
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LAST   = GW'(RETRY_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WB_ISSUE = 3'd1,
        S_OP_ISSUE = 3'd2,
        S_OP_WAIT  = 3'd3,
        S_RETRY    = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    state_e          state;
    logic [1:0]      kind_q;
    logic [31:0]     addr_q;
    logic [WW-1:0]   wait_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [GW-1:0]   gap_cnt;

    function automatic bus_operation_e op_for_kind(input logic [1:0] kind);
        case (kind)
            KIND_WR_MISS:  return BUS_RWIM;
            KIND_WR_HIT_S: return BUS_INVALIDATE;
            default:       return BUS_READ;
        endcase
    endfunction

    function automatic mesi_e install_state(input bus_operation_e op, input snoop_result_e res);
        if (op == BUS_READ)
            return (res == SNOOP_HIT) ? MESI_S : MESI_E;
        return MESI_M;
    endfunction

    // Gated by rst so the handshake is closed while reset is held.
    assign req_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            kind_q     <= 2'd0;
            addr_q     <= 32'd0;
            wait_cnt   <= '0;
            retry_cnt  <= '0;
            gap_cnt    <= '0;
            bus_valid  <= 1'b0;
            bus_op     <= BUS_READ;
            bus_addr   <= 32'd0;
            done_valid <= 1'b0;
            done_state <= MESI_I;
            err        <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        kind_q    <= req_kind;
                        addr_q    <= req_addr;
                        wait_cnt  <= '0;
                        retry_cnt <= '0;
                        gap_cnt   <= '0;
                        if (req_kind == KIND_RESERVED) begin
                            state      <= S_DONE;
                            done_valid <= 1'b1;
                            done_state <= MESI_I;
                            err        <= 1'b1;
                        end else if (victim_dirty) begin
                            state     <= S_WB_ISSUE;
                            bus_valid <= 1'b1;
                            bus_op    <= BUS_WRITE;
                            bus_addr  <= victim_addr;
                        end else begin
                            state     <= S_OP_ISSUE;
                            bus_valid <= 1'b1;
                            bus_op    <= op_for_kind(req_kind);
                            bus_addr  <= req_addr;
                        end
                    end
                end
                S_WB_ISSUE: begin
                    // Writeback needs no snoop; the real op goes out back-to-back.
                    if (bus_ready) begin
                        state    <= S_OP_ISSUE;
                        bus_op   <= op_for_kind(kind_q);
                        bus_addr <= addr_q;
                    end
                end
                S_OP_ISSUE: begin
                    if (bus_ready) begin
                        state     <= S_OP_WAIT;
                        bus_valid <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                S_OP_WAIT: begin
                    if (snoop_valid) begin
                        if (snoop_res == SNOOP_HITM && bus_op != BUS_INVALIDATE) begin
                            if (retry_cnt == RETRY_LAST) begin
                                state      <= S_DONE;
                                done_valid <= 1'b1;
                                done_state <= MESI_I;
                                err        <= 1'b1;
                            end else begin
                                retry_cnt <= retry_cnt + 1'b1;
                                gap_cnt   <= '0;
                                if (RETRY_GAP == 0) begin
                                    state     <= S_OP_ISSUE;
                                    bus_valid <= 1'b1;
                                end else begin
                                    state <= S_RETRY;
                                end
                            end
                        end else begin
                            state      <= S_DONE;
                            done_valid <= 1'b1;
                            done_state <= install_state(bus_op, snoop_res);
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= S_DONE;
                        done_valid <= 1'b1;
                        done_state <= MESI_I;
                        err        <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RETRY: begin
                    // bus_op/bus_addr still hold the original op, so reissue only raises valid.
                    if (gap_cnt == GAP_LAST) begin
                        state     <= S_OP_ISSUE;
                        bus_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    done_state <= MESI_I;
                end
                default: begin
                    state     <= S_IDLE;
                    bus_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
